// File: rtl/note_track_if.sv
// Bundle of control pulses, player keys, song ROM port and score/draw outputs
// shared between a note_track core (slave) and whatever drives it (master).
interface note_track_if;
    logic        load_song;
    logic [1:0]  song_sel;
    logic        load_note;
    logic        shift;
    logic        logic_in;
    logic        reset_score;
    logic [3:0]  keys;
    logic [7:0]  song_addr;
    logic [4:0]  song_data;
    logic [3:0]  row_sel;
    logic [3:0]  row_data;
    logic        songdone;
    logic [11:0] score;
    logic [7:0]  misses;
    logic [5:0]  combo;

    modport master (
        output load_song, song_sel, load_note, shift, logic_in, reset_score,
               keys, song_data, row_sel,
        input  song_addr, row_data, songdone, score, misses, combo
    );

    modport slave (
        input  load_song, song_sel, load_note, shift, logic_in, reset_score,
               keys, song_data, row_sel,
        output song_addr, row_data, songdone, score, misses, combo
    );
endinterface

// File: rtl/note_track.sv
// Falling-note rhythm tracker: a 16x4 grid fed row by row from an external song ROM,
// with hit judging, saturating score/miss counters. Define COMBO_EN for combo scoring.
module note_track (
    input  logic        clock,
    input  logic        resetn,
    note_track_if.slave bus
);

    logic [3:0]  grid [16];
    logic [3:0]  grid_n [16];
    logic [3:0]  next_row, next_row_n;
    logic [5:0]  index, index_n;
    logic [1:0]  song_sel_reg, song_sel_n;
    logic        end_seen, end_seen_n;
    logic [3:0]  hit_latch, hit_n;
    logic [3:0]  armed, armed_n;
    logic [11:0] score, score_n;
    logic [7:0]  misses, misses_n;
    logic        songdone, songdone_n;
`ifdef COMBO_EN
    logic [5:0]  combo, combo_n;
`endif

    logic [3:0]  miss_vec;
    logic [2:0]  miss_cnt;
    logic [8:0]  miss_sum;
    logic [3:0]  pts;
    logic [12:0] score_sum;
    logic        grid_empty;

    // A lane is armed once its key has been seen low; reset_score disarms so a held key must be re-pressed.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            grid_n[r] = grid[r];
        end
        next_row_n   = next_row;
        index_n      = index;
        song_sel_n   = song_sel_reg;
        end_seen_n   = end_seen;
        hit_n        = hit_latch;
        score_n      = score;
        misses_n     = misses;
`ifdef COMBO_EN
        combo_n      = combo;
`endif
        armed_n      = (bus.reset_score ? 4'b0000 : armed) | ~bus.keys;
        miss_vec     = grid[15] & ~hit_latch;
        miss_cnt     = {2'b00, miss_vec[0]} + {2'b00, miss_vec[1]}
                     + {2'b00, miss_vec[2]} + {2'b00, miss_vec[3]};
        miss_sum     = {1'b0, misses} + {6'b000000, miss_cnt};
        pts          = 4'd1;
        score_sum    = '0;
        grid_empty   = 1'b1;

        if (bus.load_song) begin
            for (int r = 0; r < 16; r++) begin
                grid_n[r] = 4'b0000;
            end
            next_row_n = 4'b0000;
            index_n    = 6'd0;
            song_sel_n = bus.song_sel;
            end_seen_n = 1'b0;
            hit_n      = 4'b0000;
            score_n    = 12'd0;
            misses_n   = 8'd0;
`ifdef COMBO_EN
            combo_n    = 6'd0;
`endif
        end else if (bus.shift) begin
            for (int r = 15; r > 0; r--) begin
                grid_n[r] = grid[r-1];
            end
            grid_n[0]  = next_row;
            next_row_n = 4'b0000;
            hit_n      = 4'b0000;
            misses_n   = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
`ifdef COMBO_EN
            if (miss_cnt != 3'd0) begin
                combo_n = 6'd0;
            end
`endif
        end else if (bus.load_note) begin
            if (!end_seen) begin
                index_n = index + 6'd1;
                if (bus.song_data[4] || index == 6'd63) begin
                    end_seen_n = 1'b1;
                    next_row_n = 4'b0000;
                end else begin
                    next_row_n = bus.song_data[3:0];
                end
            end else begin
                next_row_n = 4'b0000;
            end
        end else if (bus.logic_in) begin
            // Lanes are judged in order so each hit sees the combo left by the previous one.
            for (int l = 0; l < 4; l++) begin
                if (grid[15][l] && bus.keys[l] && !hit_latch[l] && armed[l]) begin
                    hit_n[l] = 1'b1;
`ifdef COMBO_EN
                    pts = 4'd1 + {1'b0, combo_n[5:3]};
                    if (combo_n != 6'd63) begin
                        combo_n = combo_n + 6'd1;
                    end
`endif
                    score_sum = {1'b0, score_n} + {9'd0, pts};
                    score_n   = (score_sum > 13'd4095) ? 12'hFFF : score_sum[11:0];
                end
            end
        end

        for (int r = 0; r < 16; r++) begin
            if (grid_n[r] != 4'b0000) begin
                grid_empty = 1'b0;
            end
        end
        songdone_n = bus.load_song ? 1'b0
                   : (songdone | (end_seen_n & grid_empty & (next_row_n == 4'b0000)));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 16; r++) begin
                grid[r] <= 4'b0000;
            end
            next_row     <= 4'b0000;
            index        <= 6'd0;
            song_sel_reg <= 2'd0;
            end_seen     <= 1'b0;
            hit_latch    <= 4'b0000;
            armed        <= 4'b0000;
            score        <= 12'd0;
            misses       <= 8'd0;
            songdone     <= 1'b0;
`ifdef COMBO_EN
            combo        <= 6'd0;
`endif
        end else begin
            for (int r = 0; r < 16; r++) begin
                grid[r] <= grid_n[r];
            end
            next_row     <= next_row_n;
            index        <= index_n;
            song_sel_reg <= song_sel_n;
            end_seen     <= end_seen_n;
            hit_latch    <= hit_n;
            armed        <= armed_n;
            score        <= score_n;
            misses       <= misses_n;
            songdone     <= songdone_n;
`ifdef COMBO_EN
            combo        <= combo_n;
`endif
        end
    end

    assign bus.song_addr = {song_sel_reg, index};
    assign bus.row_data  = grid[bus.row_sel];
    assign bus.songdone  = songdone;
    assign bus.score     = score;
    assign bus.misses    = misses;
`ifdef COMBO_EN
    assign bus.combo     = combo;
`else
    assign bus.combo     = 6'd0;
`endif

endmodule

// File: tb/tb_note_track.sv
// Directed bench for note_track: expectations are queued as each step is driven
// and popped against the DUT outputs one cycle later.
module tb_note_track;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_LS   = 5'b10000;
    localparam logic [4:0] P_SH   = 5'b01000;
    localparam logic [4:0] P_LN   = 5'b00100;
    localparam logic [4:0] P_LI   = 5'b00010;
    localparam logic [4:0] P_RS   = 5'b00001;

    localparam int S_ADDR  = 0;
    localparam int S_SCORE = 1;
    localparam int S_MISS  = 2;
    localparam int S_COMBO = 3;
    localparam int S_DONE  = 4;
    localparam int S_ROW   = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [3:0]  row;
        logic [31:0] exp;
    } exp_t;

    logic clock;
    logic resetn;
    logic [4:0] rom [256];
    exp_t sbq[$];
    int tests_run;
    int tests_failed;

    note_track_if bus();

    note_track dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    assign bus.song_data = rom[bus.song_addr];

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expect_out(input string tag, input int sel, input logic [3:0] row,
                              input logic [31:0] value);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.row = row;
        e.exp = value;
        sbq.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [4:0] pulses);
        @(negedge clock);
        bus.load_song   = pulses[4];
        bus.shift       = pulses[3];
        bus.load_note   = pulses[2];
        bus.logic_in    = pulses[1];
        bus.reset_score = pulses[0];
        @(posedge clock);
        #1;
        bus.load_song   = 1'b0;
        bus.shift       = 1'b0;
        bus.load_note   = 1'b0;
        bus.logic_in    = 1'b0;
        bus.reset_score = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                S_ADDR:  obs = 32'(bus.song_addr);
                S_SCORE: obs = 32'(bus.score);
                S_MISS:  obs = 32'(bus.misses);
                S_COMBO: obs = 32'(bus.combo);
                S_DONE:  obs = 32'(bus.songdone);
                default: begin
                    bus.row_sel = e.row;
                    #1;
                    obs = 32'(bus.row_data);
                end
            endcase
            tests_run++;
            assert (obs === e.exp) else begin
                tests_failed++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
                $error("[TB] %s: got 0x%0h expected 0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int a = 0; a < 256; a++) begin
            rom[a] = 5'b00000;
        end
        for (int a = 8'h40; a < 8'h49; a++) begin
            rom[a] = 5'b00001;
        end
        rom[8'h49] = 5'b10000;
        rom[8'h80] = 5'b00001;
        rom[8'h81] = 5'b10000;
        rom[8'hC0] = 5'b01011;
        rom[8'hC1] = 5'b00001;
        rom[8'hC2] = 5'b00010;
        rom[8'hC3] = 5'b10000;

        resetn          = 1'b0;
        bus.load_song   = 1'b0;
        bus.song_sel    = 2'd0;
        bus.load_note   = 1'b0;
        bus.shift       = 1'b0;
        bus.logic_in    = 1'b0;
        bus.reset_score = 1'b0;
        bus.keys        = 4'b0000;
        bus.row_sel     = 4'd0;

        // Reset state
        #5;
        expect_out("rst_addr", S_ADDR, 0, 32'h0);
        expect_out("rst_score", S_SCORE, 0, 32'h0);
        expect_out("rst_misses", S_MISS, 0, 32'h0);
        expect_out("rst_combo", S_COMBO, 0, 32'h0);
        expect_out("rst_done", S_DONE, 0, 32'h0);
        expect_out("rst_row15", S_ROW, 15, 32'h0);
        check_output();
        @(negedge clock);
        resetn = 1'b1;

        // Song 2: single note then end marker
        bus.song_sel = 2'd2;
        expect_out("ls2_addr", S_ADDR, 0, 32'h80);
        expect_out("ls2_score", S_SCORE, 0, 32'h0);
        expect_out("ls2_done", S_DONE, 0, 32'h0);
        apply_stimulus(P_LS);
        check_output();
        expect_out("ln1_addr", S_ADDR, 0, 32'h81);
        apply_stimulus(P_LN);
        check_output();
        expect_out("sh1_row0", S_ROW, 0, 32'h1);
        apply_stimulus(P_SH);
        check_output();
        expect_out("ln_end_addr", S_ADDR, 0, 32'h82);
        expect_out("ln_end_done", S_DONE, 0, 32'h0);
        apply_stimulus(P_LN);
        check_output();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(P_LN);
            apply_stimulus(P_SH);
        end
        expect_out("sh16_row15", S_ROW, 15, 32'h1);
        expect_out("sh16_row14", S_ROW, 14, 32'h0);
        expect_out("sh16_done", S_DONE, 0, 32'h0);
        check_output();
        bus.keys = 4'b0001;
        expect_out("hit1_score", S_SCORE, 0, 32'd1);
        apply_stimulus(P_LI);
        check_output();
        expect_out("rehit_score", S_SCORE, 0, 32'd1);
        apply_stimulus(P_LI);
        check_output();
        expect_out("sh17_misses", S_MISS, 0, 32'd0);
        expect_out("sh17_done", S_DONE, 0, 32'h1);
        expect_out("sh17_row15", S_ROW, 15, 32'h0);
        apply_stimulus(P_SH);
        check_output();
        bus.keys = 4'b0000;

        // Song 3: multi-lane miss, priority and key-release tracking
        bus.song_sel = 2'd3;
        expect_out("ls3_addr", S_ADDR, 0, 32'hC0);
        expect_out("ls3_score", S_SCORE, 0, 32'h0);
        expect_out("ls3_done", S_DONE, 0, 32'h0);
        apply_stimulus(P_LS);
        check_output();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(P_LN);
            apply_stimulus(P_SH);
        end
        apply_stimulus(P_LN);
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(P_SH);
        end
        expect_out("s3_row15", S_ROW, 15, 32'hB);
        expect_out("s3_row14", S_ROW, 14, 32'h1);
        check_output();
        expect_out("miss3_misses", S_MISS, 0, 32'd3);
        expect_out("miss3_combo", S_COMBO, 0, 32'd0);
        expect_out("miss3_row15", S_ROW, 15, 32'h1);
        apply_stimulus(P_SH);
        check_output();
        bus.keys = 4'b0001;
        expect_out("prio_misses", S_MISS, 0, 32'd4);
        expect_out("prio_score", S_SCORE, 0, 32'd0);
        expect_out("prio_row15", S_ROW, 15, 32'h2);
        apply_stimulus(P_SH | P_LI);
        check_output();
        bus.keys = 4'b0010;
        apply_stimulus(P_RS);
        expect_out("held_score", S_SCORE, 0, 32'd0);
        apply_stimulus(P_LI);
        check_output();
        bus.keys = 4'b0000;
        apply_stimulus(P_NONE);
        bus.keys = 4'b0010;
        expect_out("repress_score", S_SCORE, 0, 32'd1);
        apply_stimulus(P_LI);
        check_output();

        // Asynchronous reset between clock edges
        @(negedge clock);
        #3;
        resetn = 1'b0;
        #2;
        expect_out("arst_addr", S_ADDR, 0, 32'h0);
        expect_out("arst_score", S_SCORE, 0, 32'h0);
        expect_out("arst_misses", S_MISS, 0, 32'h0);
        expect_out("arst_done", S_DONE, 0, 32'h0);
        expect_out("arst_row15", S_ROW, 15, 32'h0);
        check_output();
        bus.keys = 4'b0000;
        @(negedge clock);
        resetn = 1'b1;

        // Song 1: nine consecutive single hits
        bus.song_sel = 2'd1;
        expect_out("ls1_addr", S_ADDR, 0, 32'h40);
        apply_stimulus(P_LS);
        check_output();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(P_LN);
            apply_stimulus(P_SH);
        end
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(P_SH);
        end
        expect_out("s1_row15", S_ROW, 15, 32'h1);
        check_output();
        for (int i = 0; i < 9; i++) begin
            bus.keys = 4'b0001;
            apply_stimulus(P_LI);
            bus.keys = 4'b0000;
            if (i == 7) begin
                expect_out("hit8_score", S_SCORE, 0, 32'd8);
                check_output();
            end
            apply_stimulus(P_SH);
        end
`ifdef COMBO_EN
        expect_out("hit9_score", S_SCORE, 0, 32'd10);
        expect_out("hit9_combo", S_COMBO, 0, 32'd9);
`else
        expect_out("hit9_score", S_SCORE, 0, 32'd9);
        expect_out("hit9_combo", S_COMBO, 0, 32'd0);
`endif
        expect_out("hit9_misses", S_MISS, 0, 32'd0);
        check_output();

        // Song 0: no end marker, end reached through the index limit
        bus.song_sel = 2'd0;
        expect_out("ls0_score", S_SCORE, 0, 32'd0);
        expect_out("ls0_done", S_DONE, 0, 32'h0);
        apply_stimulus(P_LS);
        check_output();
        for (int i = 0; i < 63; i++) begin
            apply_stimulus(P_LN);
        end
        expect_out("ln63_addr", S_ADDR, 0, 32'h3F);
        expect_out("ln63_done", S_DONE, 0, 32'h0);
        check_output();
        expect_out("ln64_done", S_DONE, 0, 32'h1);
        apply_stimulus(P_LN);
        check_output();
        expect_out("reload_done", S_DONE, 0, 32'h0);
        apply_stimulus(P_LS);
        check_output();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
